// File: rtl/seg_disp_pkg.sv
// Shared definitions for the 4-digit display path.
// Code widths, reserved codes and active-low glyph patterns.
package seg_disp_pkg;

    localparam int CODE_W = 5;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [6:0]        seg_t;

    localparam code_t CODE_BLANK = 5'd16;
    localparam code_t CODE_ERR   = 5'd15;

    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low cathodes ordered {g,f,e,d,c,b,a}
    localparam seg_t GLYPH_0 = 7'h40;
    localparam seg_t GLYPH_1 = 7'h79;
    localparam seg_t GLYPH_2 = 7'h24;
    localparam seg_t GLYPH_3 = 7'h30;
    localparam seg_t GLYPH_4 = 7'h19;
    localparam seg_t GLYPH_5 = 7'h12;
    localparam seg_t GLYPH_6 = 7'h02;
    localparam seg_t GLYPH_7 = 7'h78;
    localparam seg_t GLYPH_8 = 7'h00;
    localparam seg_t GLYPH_9 = 7'h10;
    localparam seg_t GLYPH_A = 7'h08;
    localparam seg_t GLYPH_B = 7'h03;
    localparam seg_t GLYPH_C = 7'h46;
    localparam seg_t GLYPH_D = 7'h21;
    localparam seg_t GLYPH_E = 7'h06;
    localparam seg_t GLYPH_F = 7'h0E;

    localparam logic [3:0] AN_DARK = 4'b1111;

endpackage

// File: rtl/hex7seg_decode.sv
// Code to 7-segment pattern decoder.
// Codes 0..15 are hex glyphs; 16..31 render blank.
module hex7seg_decode
    import seg_disp_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    // Upper half of the code space is reserved and always dark
    always_comb begin
        seg = SEG_OFF;
        if (!code[4]) begin
            case (code[3:0])
                4'h0:    seg = GLYPH_0;
                4'h1:    seg = GLYPH_1;
                4'h2:    seg = GLYPH_2;
                4'h3:    seg = GLYPH_3;
                4'h4:    seg = GLYPH_4;
                4'h5:    seg = GLYPH_5;
                4'h6:    seg = GLYPH_6;
                4'h7:    seg = GLYPH_7;
                4'h8:    seg = GLYPH_8;
                4'h9:    seg = GLYPH_9;
                4'hA:    seg = GLYPH_A;
                4'hB:    seg = GLYPH_B;
                4'hC:    seg = GLYPH_C;
                4'hD:    seg = GLYPH_D;
                4'hE:    seg = GLYPH_E;
                default: seg = GLYPH_F;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Time-multiplexed reader for a common-anode 4-digit display.
// Codes are snapshotted once per frame so a frame never tears.
module seg_scan_reader
    import seg_disp_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int BLINK_TICKS = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] seg0wr,
    input  logic [4:0] seg1wr,
    input  logic [4:0] seg2wr,
    input  logic [4:0] seg3wr,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic [1:0]       idx;
    logic             phase;
    code_t            snap [4];

    logic             tick;
    logic             err;
    code_t            cur_code;
    seg_t             cur_seg;

    assign tick     = (div_cnt == DIV_LAST);
    assign cur_code = snap[idx];
    assign err      = (snap[0] == CODE_ERR) && (snap[1] == CODE_ERR) &&
                      (snap[2] == CODE_ERR) && (snap[3] == CODE_ERR);

    // Decimal point is never used
    assign dp = 1'b1;

    // Slot divider: one tick per CLK_DIV cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Digit index advance; inputs captured only on the 3->0 frame wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                snap[k] <= CODE_BLANK;
            end
        end else if (tick) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
                snap[0] <= seg0wr;
                snap[1] <= seg1wr;
                snap[2] <= seg2wr;
                snap[3] <= seg3wr;
            end
        end
    end

    // Free-running blink timebase counted in digit slots
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    hex7seg_decode u_dec (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // Registered drivers; the error pattern blanks anodes in odd phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= AN_DARK;
            seg <= SEG_OFF;
        end else begin
            an  <= (err && phase) ? AN_DARK : ~(4'b0001 << idx);
            seg <= cur_seg;
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Scoreboard bench for seg_scan_reader with CLK_DIV=4, BLINK_TICKS=4.
// Stimulus queues per-slot expectations; a monitor checks each slot.
module tb_seg_scan_reader;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] seg0wr = 5'd8;
    logic [4:0] seg1wr = 5'd8;
    logic [4:0] seg2wr = 5'd8;
    logic [4:0] seg3wr = 5'd8;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    exp_t exp_q [$];
    exp_t cur;
    bit   have_cur = 0;
    int   slot_no = 0;

    logic [3:0] lit_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seg_scan_reader #(
        .CLK_DIV     (4),
        .BLINK_TICKS (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .seg0wr (seg0wr),
        .seg1wr (seg1wr),
        .seg2wr (seg2wr),
        .seg3wr (seg3wr),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    // Posedges since last reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    task automatic check_out(input string tag, input exp_t e);
        checks++;
        if (an !== e.an || seg !== e.seg || dp !== 1'b1) begin
            errors++;
            $display("FAIL %s slot %0d: an=%b seg=%h dp=%b, want an=%b seg=%h dp=1",
                     tag, slot_no, an, seg, dp, e.an, e.seg);
        end
    endtask

    // Slot s is driven after edges 4s+1 .. 4s+4; check first and last cycle
    always @(negedge clk) begin
        if (!rst) begin
            have_cur = 0;
        end else if (edges > 0 && edges % 4 == 1) begin
            slot_no = (edges - 1) / 4;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                have_cur = 1;
                check_out("slot_start", cur);
            end else begin
                have_cur = 0;
            end
        end else if (edges > 0 && edges % 4 == 0 && have_cur) begin
            check_out("slot_end", cur);
        end
    end

    task automatic push_frame(input logic dark, input logic [6:0] s0,
                              input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3);
        logic [6:0] sv [4];
        exp_t e;
        sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
        for (int d = 0; d < 4; d++) begin
            e.an  = dark ? 4'b1111 : lit_an[d];
            e.seg = sv[d];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_edge(input int n);
        while (edges != n) @(negedge clk);
    endtask

    task automatic set_codes(input logic [4:0] c3, input logic [4:0] c2,
                             input logic [4:0] c1, input logic [4:0] c0);
        seg3wr = c3; seg2wr = c2; seg1wr = c1; seg0wr = c0;
    endtask

    task automatic check_dark(input string tag);
        exp_t e;
        e.an = 4'b1111;
        e.seg = 7'h7F;
        slot_no = -1;
        check_out(tag, e);
    endtask

    task automatic check_q_empty(input string tag);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected slots never observed, want 0",
                     tag, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_dark("reset_init");
        push_frame(1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        rst = 1'b1;

        wait_edge(8);
        set_codes(5'd0, 5'd4, 5'd8, 5'd5);
        push_frame(1'b0, 7'h12, 7'h00, 7'h19, 7'h40);

        wait_edge(20);
        seg0wr = 5'd1;

        wait_edge(24);
        push_frame(1'b0, 7'h79, 7'h00, 7'h19, 7'h40);

        wait_edge(40);
        set_codes(5'd15, 5'd15, 5'd15, 5'd15);
        push_frame(1'b1, 7'h0E, 7'h0E, 7'h0E, 7'h0E);

        wait_edge(56);
        push_frame(1'b0, 7'h0E, 7'h0E, 7'h0E, 7'h0E);

        wait_edge(72);
        push_frame(1'b1, 7'h0E, 7'h0E, 7'h0E, 7'h0E);

        wait_edge(88);
        set_codes(5'd13, 5'd10, 5'd31, 5'd16);
        push_frame(1'b0, 7'h7F, 7'h7F, 7'h08, 7'h21);

        wait_edge(104);
        set_codes(5'd7, 5'd6, 5'd3, 5'd2);
        push_frame(1'b0, 7'h24, 7'h30, 7'h02, 7'h78);

        wait_edge(120);
        set_codes(5'd15, 5'd12, 5'd11, 5'd9);
        push_frame(1'b0, 7'h10, 7'h03, 7'h46, 7'h0E);

        wait_edge(146);
        check_q_empty("run1_drain");
        #2;
        rst = 1'b0;
        #1;
        check_dark("reset_async");

        @(negedge clk);
        check_dark("reset_hold");
        push_frame(1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        rst = 1'b1;

        wait_edge(8);
        push_frame(1'b0, 7'h10, 7'h03, 7'h46, 7'h0E);

        wait_edge(40);
        check_q_empty("run2_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
